// File: rtl/cnn_layer_scheduler.sv
// Top-level sequencer for the two-layer CNN pipeline.
// Starts layer 1 and gives it the shared OFM port while it writes. After a
// fixed drain interval it starts layer 2 and gives the port to the layer-2
// window reader. It also counts accepted writes and flags protocol and
// range errors for the current run.
module cnn_layer_scheduler #(
  parameter int OFM_DEPTH    = 172,
  parameter int ADDR_W       = $clog2(OFM_DEPTH),
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              l1_done,
  input  logic              l2_done,
  input  logic              l1_wr_req,
  input  logic [ADDR_W-1:0] l1_wr_addr,
  input  logic              l2_rd_req,
  input  logic [ADDR_W-1:0] l2_rd_addr,
  output logic              l1_start,
  output logic              l2_start,
  output logic              l1_wr_gnt,
  output logic              l2_rd_gnt,
  output logic [ADDR_W-1:0] ofm_addr,
  output logic              ofm_wr_en,
  output logic [ADDR_W:0]   wr_count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    L1_RUN = 3'd1,
    DRAIN  = 3'd2,
    L2_RUN = 3'd3,
    FINISH = 3'd4
  } state_t;

  // One extra bit so that a depth equal to 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DEPTH_W    = (ADDR_W+1)'(OFM_DEPTH);
  // The drain counter counts up from 0 on each DRAIN cycle.
  localparam logic [3:0]      DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] drain_cnt;
  logic       start_acc;
  logic       l2_go;
  logic       l1_in_range;
  logic       l2_in_range;
  logic       err_set;

  assign l1_in_range = ({1'b0, l1_wr_addr} < DEPTH_W);
  assign l2_in_range = ({1'b0, l2_rd_addr} < DEPTH_W);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and OFM port arbitration.
  // A request in the completion cycle is still granted.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    l2_go     = 1'b0;
    l1_wr_gnt = 1'b0;
    l2_rd_gnt = 1'b0;
    ofm_wr_en = 1'b0;
    ofm_addr  = '0;
    busy      = 1'b0;
    case (state)
      IDLE, FINISH: begin
        if (start) begin
          state_nxt = L1_RUN;
          start_acc = 1'b1;
        end
      end
      L1_RUN: begin
        busy      = 1'b1;
        l1_wr_gnt = l1_wr_req && l1_in_range;
        ofm_wr_en = l1_wr_req && l1_in_range;
        ofm_addr  = l1_wr_addr;
        if (l1_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = L2_RUN;
          l2_go     = 1'b1;
        end
      end
      L2_RUN: begin
        busy      = 1'b1;
        l2_rd_gnt = l2_rd_req && l2_in_range;
        ofm_addr  = l2_rd_addr;
        if (l2_done) state_nxt = FINISH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Error sources: a write outside L1_RUN or out of range, an out-of-range
  // read in L2_RUN, and a write accepted after the count has saturated.
  // A layer-2 read before L2_RUN only stalls and is not an error.
  always_comb begin
    err_set = 1'b0;
    if (l1_wr_req && !((state == L1_RUN) && l1_in_range)) err_set = 1'b1;
    if ((state == L2_RUN) && l2_rd_req && !l2_in_range)   err_set = 1'b1;
    if (l1_wr_gnt && (wr_count == DEPTH_W))               err_set = 1'b1;
  end

  // Drain interval counter; only advances while in DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  drain_cnt <= 4'd0;
    else if (state == DRAIN)  drain_cnt <= drain_cnt + 4'd1;
    else                      drain_cnt <= 4'd0;
  end

  // Registered start pulses, high in the first cycle of the new phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l1_start <= 1'b0;
      l2_start <= 1'b0;
    end else begin
      l1_start <= start_acc;
      l2_start <= l2_go;
    end
  end

  // Accepted-write counter, cleared by an accepted start, saturating at depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     wr_count <= '0;
    else if (start_acc)                          wr_count <= '0;
    else if (l1_wr_gnt && (wr_count != DEPTH_W)) wr_count <= wr_count + 1'b1;
  end

  // Run-complete and sticky error flags, both cleared by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else if (start_acc) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      if ((state == L2_RUN) && l2_done) done <= 1'b1;
      if (err_set)                      err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Bench for cnn_layer_scheduler: two instances (drain 2 and drain 5) share
// one stimulus stream and are compared every cycle against a phase-level
// reference model of the sequencer.
module tb_cnn_layer_scheduler;

  localparam int DEPTH = 172;
  localparam int AW    = 8;
  localparam int DC0   = 2;
  localparam int DC1   = 5;

  localparam int P_IDLE = 0, P_L1 = 1, P_DRAIN = 2, P_L2 = 3, P_FIN = 4;

  logic          clk, rst;
  logic          start, l1_done, l2_done, l1_wr_req, l2_rd_req;
  logic [AW-1:0] l1_wr_addr, l2_rd_addr;

  logic [1:0]    l1_start_o, l2_start_o, l1_wr_gnt_o, l2_rd_gnt_o;
  logic [1:0]    ofm_wr_en_o, busy_o, done_o, err_o;
  logic [AW-1:0] ofm_addr_o [2];
  logic [AW:0]   wr_count_o [2];

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state per instance
  int m_phase [2];
  int m_left  [2];
  int m_cnt   [2];
  bit m_err   [2];
  bit m_done  [2];
  bit m_l1s   [2];
  bit m_l2s   [2];
  int m_dc    [2];

  cnn_layer_scheduler #(.OFM_DEPTH(DEPTH), .ADDR_W(AW), .DRAIN_CYCLES(DC0)) u0 (
    .clk(clk), .rst(rst), .start(start), .l1_done(l1_done), .l2_done(l2_done),
    .l1_wr_req(l1_wr_req), .l1_wr_addr(l1_wr_addr),
    .l2_rd_req(l2_rd_req), .l2_rd_addr(l2_rd_addr),
    .l1_start(l1_start_o[0]), .l2_start(l2_start_o[0]),
    .l1_wr_gnt(l1_wr_gnt_o[0]), .l2_rd_gnt(l2_rd_gnt_o[0]),
    .ofm_addr(ofm_addr_o[0]), .ofm_wr_en(ofm_wr_en_o[0]),
    .wr_count(wr_count_o[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0])
  );

  cnn_layer_scheduler #(.OFM_DEPTH(DEPTH), .ADDR_W(AW), .DRAIN_CYCLES(DC1)) u1 (
    .clk(clk), .rst(rst), .start(start), .l1_done(l1_done), .l2_done(l2_done),
    .l1_wr_req(l1_wr_req), .l1_wr_addr(l1_wr_addr),
    .l2_rd_req(l2_rd_req), .l2_rd_addr(l2_rd_addr),
    .l1_start(l1_start_o[1]), .l2_start(l2_start_o[1]),
    .l1_wr_gnt(l1_wr_gnt_o[1]), .l2_rd_gnt(l2_rd_gnt_o[1]),
    .ofm_addr(ofm_addr_o[1]), .ofm_wr_en(ofm_wr_en_o[1]),
    .wr_count(wr_count_o[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dc[0] = DC0;
    m_dc[1] = DC1;
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = P_IDLE; m_left[k] = 0; m_cnt[k] = 0;
      m_err[k] = 0; m_done[k] = 0; m_l1s[k] = 0; m_l2s[k] = 0;
    end
  endtask

  // Compare every output of both instances with the model for current inputs.
  task automatic compare_outputs();
    for (int k = 0; k < 2; k++) begin
      bit l1_ok, l2_ok, g1, g2, bz;
      int ea;
      l1_ok = (int'(l1_wr_addr) < DEPTH);
      l2_ok = (int'(l2_rd_addr) < DEPTH);
      g1 = (m_phase[k] == P_L1) && l1_wr_req && l1_ok;
      g2 = (m_phase[k] == P_L2) && l2_rd_req && l2_ok;
      ea = (m_phase[k] == P_L1) ? int'(l1_wr_addr) :
           (m_phase[k] == P_L2) ? int'(l2_rd_addr) : 0;
      bz = (m_phase[k] == P_L1) || (m_phase[k] == P_DRAIN) || (m_phase[k] == P_L2);
      chk($sformatf("u%0d.l1_wr_gnt", k), 32'(l1_wr_gnt_o[k]), 32'(g1));
      chk($sformatf("u%0d.l2_rd_gnt", k), 32'(l2_rd_gnt_o[k]), 32'(g2));
      chk($sformatf("u%0d.ofm_wr_en", k), 32'(ofm_wr_en_o[k]), 32'(g1));
      chk($sformatf("u%0d.ofm_addr", k),  32'(ofm_addr_o[k]),  32'(ea));
      chk($sformatf("u%0d.busy", k),      32'(busy_o[k]),      32'(bz));
      chk($sformatf("u%0d.done", k),      32'(done_o[k]),      32'(m_done[k]));
      chk($sformatf("u%0d.err", k),       32'(err_o[k]),       32'(m_err[k]));
      chk($sformatf("u%0d.wr_count", k),  32'(wr_count_o[k]),  32'(m_cnt[k]));
      chk($sformatf("u%0d.l1_start", k),  32'(l1_start_o[k]),  32'(m_l1s[k]));
      chk($sformatf("u%0d.l2_start", k),  32'(l2_start_o[k]),  32'(m_l2s[k]));
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit l1_ok, l2_ok, g1;
      l1_ok = (int'(l1_wr_addr) < DEPTH);
      l2_ok = (int'(l2_rd_addr) < DEPTH);
      g1 = (m_phase[k] == P_L1) && l1_wr_req && l1_ok;
      if (l1_wr_req && !g1) m_err[k] = 1;
      if ((m_phase[k] == P_L2) && l2_rd_req && !l2_ok) m_err[k] = 1;
      if (g1) begin
        if (m_cnt[k] == DEPTH) m_err[k] = 1;
        else m_cnt[k]++;
      end
      m_l1s[k] = 0;
      m_l2s[k] = 0;
      case (m_phase[k])
        P_IDLE, P_FIN: if (start) begin
          m_phase[k] = P_L1; m_l1s[k] = 1;
          m_done[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
        end
        P_L1: if (l1_done) begin
          m_phase[k] = P_DRAIN; m_left[k] = m_dc[k];
        end
        P_DRAIN: begin
          m_left[k]--;
          if (m_left[k] == 0) begin m_phase[k] = P_L2; m_l2s[k] = 1; end
        end
        P_L2: if (l2_done) begin m_phase[k] = P_FIN; m_done[k] = 1; end
        default: ;
      endcase
    end
  endtask

  task automatic step();
    #1 compare_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 0; l1_done = 0; l2_done = 0;
    l1_wr_req = 0; l1_wr_addr = '0; l2_rd_req = 0; l2_rd_addr = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    #1 compare_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Clean run: 172 writes, l1_done with the last; reader waiting on addr 5;
    // start pulses during L1_RUN and DRAIN are ignored.
    start = 1; step(); start = 0;
    l2_rd_req = 1; l2_rd_addr = 8'd5;
    for (int i = 0; i < DEPTH; i++) begin
      l1_wr_req = 1; l1_wr_addr = AW'(i);
      l1_done = (i == DEPTH - 1);
      start = (i == 50);
      step();
    end
    l1_wr_req = 0; l1_done = 0;
    start = 1; step(); start = 0;
    for (int j = 0; j < 180; j++) begin
      l2_rd_addr = (j < 6) ? 8'd5 : AW'(j % DEPTH);
      step();
    end
    l2_done = 1; l2_rd_req = 0; step(); l2_done = 0;
    step();

    // Second run from FINISH: saturation, out-of-range writes, late writer,
    // out-of-range read.
    start = 1; step(); start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      l1_wr_req = 1; l1_wr_addr = AW'(i); step();
    end
    l1_wr_addr = 8'd0; step();
    l1_wr_addr = 8'd172; step();
    l1_wr_addr = 8'd255; l1_done = 1; step();
    l1_done = 0; l1_wr_addr = 8'd3; step();
    l1_wr_req = 0;
    for (int i = 0; i < 6; i++) step();
    l2_rd_req = 1; l2_rd_addr = 8'd200; step();
    l2_rd_addr = 8'd171; l2_done = 1; step();
    l2_rd_req = 0; l2_done = 0; step();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      start      = ($urandom_range(0, 29) == 0);
      l1_done    = ($urandom_range(0, 24) == 0);
      l2_done    = ($urandom_range(0, 24) == 0);
      l1_wr_req  = $urandom_range(0, 1) == 1;
      l2_rd_req  = $urandom_range(0, 1) == 1;
      l1_wr_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(172, 255)) : AW'($urandom_range(0, 171));
      l2_rd_addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(172, 255)) : AW'($urandom_range(0, 171));
      step();
    end
    idle_inputs();
    step();

    // Reset asserted in the middle of L2_RUN with a pending read.
    while (m_phase[0] != P_IDLE && m_phase[0] != P_FIN) begin
      l1_done = 1; l2_done = (m_phase[0] == P_L2) && (m_phase[1] == P_L2); step();
      if (tests_run > 400000) break;
    end
    idle_inputs();
    for (int i = 0; i < 8 && (m_phase[1] != P_IDLE && m_phase[1] != P_FIN); i++) begin
      l1_done = 1; l2_done = (m_phase[1] == P_L2); step();
    end
    idle_inputs();
    start = 1; step(); start = 0;
    l1_done = 1; step(); l1_done = 0;
    for (int i = 0; i < 6; i++) step();
    l2_rd_req = 1; l2_rd_addr = 8'd7;
    #1 compare_outputs();
    #2 rst = 1'b1;
    model_reset();
    #1 compare_outputs();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cnn_layer_scheduler.md
Name: cnn_layer_scheduler

Overview:
Top-level sequencer for the two-layer CNN pipeline. It starts layer 1 and owns the single OFM memory port while layer 1 writes. It then waits a fixed drain interval, starts layer 2 and hands the OFM port to the layer-2 window reader. It replaces the ad-hoc two-bit select on the OFM address mux with one arbitrated port, and adds phase tracking, write accounting and error flagging.

Parameters:
OFM_DEPTH, 172, number of words in each OFM memory
ADDR_W, $clog2(OFM_DEPTH) (8), OFM address width
DRAIN_CYCLES, 2, idle cycles between layer-1 done and layer-2 start (range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  run request; sampled only in IDLE or FINISH
l1_done  input  1  layer-1 completion pulse
l2_done  input  1  layer-2 completion pulse
l1_wr_req  input  1  layer-1 OFM write request
l1_wr_addr  input  ADDR_W  layer-1 OFM write address
l2_rd_req  input  1  layer-2 OFM read request
l2_rd_addr  input  ADDR_W  layer-2 OFM read address
l1_start  output  1  one-cycle start pulse to layer 1
l2_start  output  1  one-cycle start pulse to layer 2
l1_wr_gnt  output  1  layer-1 write accepted this cycle
l2_rd_gnt  output  1  layer-2 read accepted this cycle
ofm_addr  output  ADDR_W  shared OFM port address
ofm_wr_en  output  1  shared OFM write enable
wr_count  output  ADDR_W+1  accepted layer-1 writes in the current run
busy  output  1  high in L1_RUN, DRAIN and L2_RUN
done  output  1  run complete; held until the next start
err  output  1  sticky protocol/range error for the current run

Behaviour:
- Reset (async): state=IDLE. l1_start, l2_start, done and err are 0. wr_count and the drain counter are 0. All grants and ofm_wr_en are 0, and ofm_addr=0.
- States and transitions:
  - IDLE: start -> L1_RUN.
  - L1_RUN: l1_done -> DRAIN.
  - DRAIN: after DRAIN_CYCLES cycles -> L2_RUN.
  - L2_RUN: l2_done -> FINISH.
  - FINISH: start -> L1_RUN.
- l1_start is registered. It is high exactly in the first cycle of L1_RUN. l2_start is high exactly in the first cycle of L2_RUN.
- Leaving IDLE or FINISH on start clears done, err and wr_count in the same edge.
- start is ignored while busy=1.
- Port grants (combinational from state and inputs, zero latency):
  - L1_RUN: l1_wr_gnt = l1_wr_req && (l1_wr_addr < OFM_DEPTH). ofm_wr_en = l1_wr_gnt. ofm_addr = l1_wr_addr.
  - L2_RUN: l2_rd_gnt = l2_rd_req && (l2_rd_addr < OFM_DEPTH). ofm_wr_en = 0. ofm_addr = l2_rd_addr.
  - IDLE, DRAIN, FINISH: no grants, ofm_wr_en=0, ofm_addr=0.
- Out-of-range request (addr >= OFM_DEPTH) in its own phase: not granted; err set on the next edge.
- l1_wr_req outside L1_RUN: not granted; err set (late writer).
- l2_rd_req in L1_RUN or DRAIN: not granted, no error. The reader stalls.
- Completion-cycle rule: a request in the same cycle as l1_done or l2_done is still granted, then the state advances.
- l2_done outside L2_RUN and l1_done outside L1_RUN: ignored, no error.
- wr_count increments on every l1_wr_gnt and saturates at OFM_DEPTH; a further grant at saturation also sets err.
- done is registered: high from the first cycle of FINISH until the cycle after start is accepted.
- busy is decoded combinationally from state.

Test Plan:
1. Reset mid-L2_RUN with l2_rd_req=1 -> same cycle, ofm_addr=0, all grants 0, busy=0, done=0. After release, state IDLE and wr_count=0.
2. start pulse; layer 1 writes addresses 0..171 one per cycle; l1_done with the last write; l2 reads 0..171; l2_done -> l1_start and l2_start each high exactly one cycle; l2_start exactly 2 cycles after the l1_done cycle + 1; wr_count=172; done=1; err=0.
3. In L1_RUN, l1_wr_req with l1_wr_addr=172 -> l1_wr_gnt=0, ofm_wr_en=0, err=1 next cycle, wr_count unchanged.
4. l2_rd_req=1, addr 5, held during L1_RUN and DRAIN -> l2_rd_gnt=0 throughout. Grant=1 and ofm_addr=5 in the first L2_RUN cycle; err=0.
5. start asserted during L1_RUN and DRAIN -> ignored, no extra l1_start. start in FINISH -> done drops next cycle, wr_count and err clear, l1_start pulses once.
6. l1_wr_req=1 in DRAIN with addr 3 -> ofm_wr_en=0 and err=1. Set DRAIN_CYCLES=5 -> l2_start asserts 5 cycles after DRAIN entry.
